// File: rtl/signed_seq_multiplier.sv
// ---------------------------------------------------------------------------------------------
// signed_seq_multiplier
//
// Sequential two's-complement multiplier. Operands are accepted on a valid/ready handshake,
// converted to sign + magnitude, and multiplied one bit of the multiplier per cycle with a
// shift-add loop. The sign is re-applied in a single step, and the 2*WIDTH-bit result is held
// until the consumer takes it.
//
// Parameters:
//   WIDTH      operand width in bits, 2..32 (default 8)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   a, b       WIDTH-bit two's-complement operands, sampled only on the accept edge
//   in_valid   operands presented
//   in_ready   block can accept operands (high only while idle)
//   product    2*WIDTH-bit two's-complement product, held while out_valid is high
//   out_valid  product is valid
//   out_ready  consumer accepts the product
//   busy       high whenever an operation is in flight or awaiting the out handshake
//
// Build option:
//   SIGNED_MUL_ZERO_SKIP_EN  when defined, a zero operand skips the shift-add loop. The result
//                            (always 0) then appears one cycle after accept. The handshake is
//                            unchanged. When undefined, zero operands take the full latency.
//
// Latency: accept edge 0, MUL on edges 1..WIDTH, product/out_valid registered on edge WIDTH+1.
// ---------------------------------------------------------------------------------------------
module signed_seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("signed_seq_multiplier: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StSign,
        StDone
    } state_e;

    state_e           state_q;
    logic             sign_q;
    logic [WIDTH-1:0] mag_a_q;
    logic [WIDTH-1:0] mag_b_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;

    // Magnitude as an unsigned WIDTH-bit value; the most-negative input maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Step index counts up as the counter counts down from WIDTH.
    logic [CW-1:0] step_idx;
    logic [PW-1:0] partial;

    assign step_idx = CW'(WIDTH) - cnt_q;
    assign partial  = {{WIDTH{1'b0}}, mag_a_q} << step_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sign_q    <= 1'b0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                        mag_a_q  <= magnitude(a);
                        mag_b_q  <= magnitude(b);
                        acc_q    <= '0;
                        cnt_q    <= CW'(WIDTH);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef SIGNED_MUL_ZERO_SKIP_EN
                        // A zero operand leaves the cleared accumulator as the answer; going
                        // straight to SIGN yields product=0 with out_valid one cycle later.
                        if (a == '0 || b == '0) begin
                            state_q <= StSign;
                        end else begin
                            state_q <= StMul;
                        end
`else
                        state_q  <= StMul;
`endif
                    end
                end

                StMul: begin
                    if (mag_b_q[0]) begin
                        acc_q <= acc_q + partial;
                    end
                    mag_b_q <= mag_b_q >> 1;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= StSign;
                    end
                end

                StSign: begin
                    // Negating a zero accumulator gives zero, so -0 never escapes.
                    product   <= sign_q ? (~acc_q + PW'(1)) : acc_q;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end

                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Handshake invariants.
    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_busy_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
        busy == !in_ready);

    a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(product)));

endmodule

// File: tb/tb_signed_seq_multiplier.sv
module tb_signed_seq_multiplier;

    localparam int W  = 8;
    localparam int W4 = 4;

`ifdef SIGNED_MUL_ZERO_SKIP_EN
    localparam bit ZeroSkip = 1'b1;
`else
    localparam bit ZeroSkip = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic [W-1:0]   a, b;
    logic           in_valid, in_ready, out_valid, out_ready, busy;
    logic [2*W-1:0] product;

    // WIDTH=4 instance for the exhaustive sweep
    logic [W4-1:0]   a4, b4;
    logic            in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [2*W4-1:0] product4;

    int n_tests = 0;
    int n_fail  = 0;

    signed_seq_multiplier #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    signed_seq_multiplier #(.WIDTH(W4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a4),
        .b         (b4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .product   (product4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .busy      (busy4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the WIDTH=8 block: idle, then a countdown of the operation's
    // latency, then a held result until the consumer takes it.
    logic        m_busy, m_valid;
    int          m_cnt;
    logic [15:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
            m_prod  = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy  = 1'b1;
                m_valid = 1'b0;
                m_prod  = 16'(int'($signed(a)) * int'($signed(b)));
                m_cnt   = (ZeroSkip && (a == 0 || b == 0)) ? 1 : W + 1;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
            end
        end else begin
            m_cnt--;
            m_valid = (m_cnt == 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, !m_busy);
            check("busy", busy, m_busy);
            check("out_valid", out_valid, m_valid);
            if (m_valid) check("product", product, m_prod);
        end
    end

    // One WIDTH=8 operation: expected product and latency are given/derived by the caller side.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp,
                         input int hold, input bit early, input string name);
        int t;
        int lat;
        lat = (ZeroSkip && (ta == 0 || tb_v == 0)) ? 1 : W + 1;
        @(negedge clk);
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        t        = 0;
        while (!out_valid && t < 4 * W) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_lat"}, t, lat);
        check(name, product, exp);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = i[0];
                @(posedge clk);
                #1;
                check({name, "_held"}, product, exp);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [7:0]  ra, rb;
    logic [15:0] rexp;
    logic [3:0]  x4, y4;
    logic [7:0]  e4;
    int          t4, l4;

    initial begin
        rst_n      = 1'b0;
        a          = '0;
        b          = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a4         = '0;
        b4         = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_product", product, 16'h0000);
        check("rst4_in_ready", in_ready4, 1'b1);
        check("rst4_product", product4, 8'h00);
        #1 rst_n = 1'b1;

        // Directed vectors with hand-computed products
        do_op(8'd7,   8'hFD, 16'hFFEB, 0, 1'b0, "p7_m3");
        do_op(8'h80,  8'h80, 16'h4000, 0, 1'b1, "m128_m128");
        do_op(8'h80,  8'h7F, 16'hC080, 0, 1'b0, "m128_p127");
        do_op(8'hFF,  8'hFF, 16'h0001, 0, 1'b1, "m1_m1");
        do_op(8'd0,   8'hFB, 16'h0000, 0, 1'b0, "zero_m5");
        do_op(8'hFB,  8'd0,  16'h0000, 0, 1'b1, "m5_zero");
        do_op(8'h7F,  8'h7F, 16'h3F01, 0, 1'b0, "p127_p127");
        do_op(8'd12,  8'hF6, 16'hFF88, 5, 1'b0, "backpressure");

        // Abort during MUL step 4
        @(negedge clk);
        a         = 8'd100;
        b         = 8'd77;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_product", product, 16'h0000);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (W + 3) @(posedge clk);
        #1 check("abort_no_stale", out_valid, 1'b0);
        do_op(8'd5, 8'd6, 16'h001E, 0, 1'b0, "after_abort");

        // Random signed pairs
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rexp = 16'(int'($signed(ra)) * int'($signed(rb)));
            do_op(ra, rb, rexp, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rand");
        end

        // Exhaustive WIDTH=4 sweep, back-to-back with out_ready held high
        out_ready4 = 1'b1;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                x4 = 4'(ia);
                y4 = 4'(ib);
                e4 = 8'(int'($signed(x4)) * int'($signed(y4)));
                l4 = (ZeroSkip && (x4 == 0 || y4 == 0)) ? 1 : W4 + 1;
                @(negedge clk);
                a4        = x4;
                b4        = y4;
                in_valid4 = 1'b1;
                @(posedge clk);
                #1 in_valid4 = 1'b0;
                t4 = 0;
                while (!out_valid4 && t4 < 4 * W4) begin
                    @(posedge clk);
                    #1;
                    t4++;
                end
                check("w4_lat", t4, l4);
                check("w4_product", product4, e4);
                @(posedge clk);
                #1;
                check("w4_released", out_valid4, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
